// File: rtl/ibex_instr_responder.sv
// Instruction-fetch responder for an Ibex-style req/gnt/rvalid interface.
// Grants fetches into an in-order response FIFO backed by a preloadable word memory.
module ibex_instr_responder #(
    parameter int unsigned MemWords = 1024,
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned Depth    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         gnt_stall_i,
    input  logic                         rsp_stall_i,
    input  logic                         load_we_i,
    input  logic [$clog2(MemWords)-1:0]  load_addr_i,
    input  logic [31:0]                  load_wdata_i,
    output logic                         busy_o,
    output logic [$clog2(Depth+1)-1:0]   outstanding_o
);
    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [33:0] MemBytes = 34'(MemWords) * 34'd4;

    logic [31:0]   r_mem       [MemWords];
    logic [31:0]   r_fifo_data [Depth];
    logic          r_fifo_err  [Depth];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [33:0]   w_diff;
    logic          w_addr_ok;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_fetch_data;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(Depth - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // A 34-bit difference turns "below base" into a sign bit and avoids wrap above the top.
    assign w_diff       = {2'b00, instr_addr_i} - {2'b00, BaseAddr};
    assign w_addr_ok    = (instr_addr_i[1:0] == 2'b00) && !w_diff[33] && (w_diff < MemBytes);
    assign w_idx        = AW'(w_diff >> 2);
    assign w_fetch_data = w_addr_ok ? r_mem[w_idx] : '0;

    // The response popped this cycle does not free a slot for a grant in the same cycle.
    assign w_push = instr_req_i & ~gnt_stall_i & (r_count < CW'(Depth));
    assign w_pop  = (r_count != '0) & ~rsp_stall_i;

    assign instr_gnt_o    = w_push;
    assign instr_rvalid_o = w_pop;
    assign instr_rdata_o  = w_pop ? r_fifo_data[r_rptr] : '0;
    assign instr_err_o    = w_pop ? r_fifo_err[r_rptr] : 1'b0;
    assign busy_o         = (r_count != '0);
    assign outstanding_o  = r_count;

    // NOTE: storage arrays carry no reset; only pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= w_fetch_data;
            r_fifo_err[r_wptr]  <= ~w_addr_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_instr_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch responder.
module tb_ibex_instr_responder;
    localparam int          MEM_WORDS = 16;
    localparam int          DEPTH     = 2;
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          instr_err_o;
    logic          gnt_stall_i;
    logic          rsp_stall_i;
    logic          load_we_i;
    logic [AW-1:0] load_addr_i;
    logic [31:0]   load_wdata_i;
    logic          busy_o;
    logic [CW-1:0] outstanding_o;

    always #5 clk_i = ~clk_i;

    ibex_instr_responder #(
        .MemWords (MEM_WORDS),
        .BaseAddr (BASE),
        .Depth    (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .gnt_stall_i    (gnt_stall_i),
        .rsp_stall_i    (rsp_stall_i),
        .load_we_i      (load_we_i),
        .load_addr_i    (load_addr_i),
        .load_wdata_i   (load_wdata_i),
        .busy_o         (busy_o),
        .outstanding_o  (outstanding_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_q[$];
    logic [31:0] ref_mem [MEM_WORDS];

    logic        seen_gnt;
    logic        seen_rv;
    logic [31:0] seen_rdata;
    logic        seen_err;
    logic [31:0] seen_out;

    logic        got_gnt  [8];
    logic        got_rv   [8];
    logic [31:0] got_data [8];
    logic [31:0] got_out  [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Fetch result as described by the address rules: alignment, lower and upper bound.
    function automatic rsp_t ref_fetch(input logic [31:0] a);
        rsp_t   r;
        longint ua = longint'(a);
        longint lo = longint'(BASE);
        longint hi = lo + 4 * MEM_WORDS;
        if ((ua % 4) != 0 || ua < lo || ua >= hi) begin
            r.data = '0;
            r.err  = 1'b1;
        end else begin
            r.data = ref_mem[int'((ua - lo) / 4)];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        bit   eg;
        bit   ev;
        rsp_t e;
        int   n;
        @(negedge clk_i);
        n  = exp_q.size();
        eg = instr_req_i && !gnt_stall_i && (n < DEPTH);
        ev = (n != 0) && !rsp_stall_i;
        e  = ev ? exp_q[0] : '0;
        check("gnt",         32'(instr_gnt_o),    32'(eg));
        check("rvalid",      32'(instr_rvalid_o), 32'(ev));
        check("rdata",       instr_rdata_o,       e.data);
        check("err",         32'(instr_err_o),    32'(e.err));
        check("busy",        32'(busy_o),         32'(n != 0));
        check("outstanding", 32'(outstanding_o),  32'(n));
        seen_gnt   = instr_gnt_o;
        seen_rv    = instr_rvalid_o;
        seen_rdata = instr_rdata_o;
        seen_err   = instr_err_o;
        seen_out   = 32'(outstanding_o);
        @(posedge clk_i);
        if (rst_ni) begin
            if (eg) exp_q.push_back(ref_fetch(instr_addr_i));
            if (ev) void'(exp_q.pop_front());
        end
        if (load_we_i) ref_mem[load_addr_i] = load_wdata_i;
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        gnt_stall_i  = 1'b0;
        rsp_stall_i  = 1'b0;
        load_we_i    = 1'b0;
        load_addr_i  = '0;
        load_wdata_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Reset state, including a combinational grant while held in reset.
        cycle();
        check("rst_rvalid", 32'(seen_rv), 32'd0);
        check("rst_out",    seen_out,     32'd0);
        instr_req_i = 1'b1;
        cycle();
        check("rst_gnt", 32'(seen_gnt), 32'd1);
        instr_req_i = 1'b0;
        cycle();
        rst_ni = 1'b1;
        cycle();

        // Preload memory.
        for (int i = 0; i < MEM_WORDS; i++) begin
            load_we_i    = 1'b1;
            load_addr_i  = AW'(i);
            case (i)
                0:       load_wdata_i = 32'h0000_0013;
                1:       load_wdata_i = 32'h0000_000A;
                2:       load_wdata_i = 32'h0000_000B;
                3:       load_wdata_i = 32'h0000_0044;
                default: load_wdata_i = $urandom;
            endcase
            cycle();
        end
        load_we_i = 1'b0;

        // Single fetch, one-cycle latency.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        cycle();
        check("t34_gnt", 32'(seen_gnt), 32'd1);
        instr_req_i = 1'b0;
        cycle();
        check("t34_rvalid", 32'(seen_rv), 32'd1);
        check("t34_rdata",  seen_rdata,   32'h0000_0013);
        check("t34_err",    32'(seen_err), 32'd0);

        // Back-to-back fetches.
        for (int k = 0; k < 5; k++) begin
            instr_req_i  = (k < 3);
            instr_addr_i = 32'(4 * k);
            cycle();
            got_gnt[k]  = seen_gnt;
            got_rv[k]   = seen_rv;
            got_data[k] = seen_rdata;
        end
        check("t35_gnt0",  32'(got_gnt[0]), 32'd1);
        check("t35_gnt2",  32'(got_gnt[2]), 32'd1);
        check("t35_rv0",   32'(got_rv[0]),  32'd0);
        check("t35_rv3",   32'(got_rv[3]),  32'd1);
        check("t35_rv4",   32'(got_rv[4]),  32'd0);
        check("t35_data1", got_data[1], 32'h13);
        check("t35_data2", got_data[2], 32'h0A);
        check("t35_data3", got_data[3], 32'h0B);

        // Response stall fills the FIFO and blocks further grants.
        rsp_stall_i  = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h8;
        for (int k = 0; k < 4; k++) begin
            cycle();
            got_gnt[k] = seen_gnt;
            got_out[k] = seen_out;
        end
        check("t36_gnt1", 32'(got_gnt[1]), 32'd1);
        check("t36_gnt2", 32'(got_gnt[2]), 32'd0);
        check("t36_gnt3", 32'(got_gnt[3]), 32'd0);
        check("t36_out3", got_out[3],      32'd2);
        rsp_stall_i = 1'b0;
        cycle();
        check("t36_rel_gnt", 32'(seen_gnt), 32'd0);
        check("t36_rel_rv",  32'(seen_rv),  32'd1);
        check("t36_rel_dat", seen_rdata,    32'h0B);
        cycle();
        check("t36_resume_gnt", 32'(seen_gnt), 32'd1);
        instr_req_i = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

        // Misaligned and past-the-end fetches.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h2;
        cycle();
        instr_addr_i = 32'(4 * MEM_WORDS);
        cycle();
        check("t37_gnt_hi", 32'(seen_gnt), 32'd1);
        check("t37_err_mis", 32'(seen_err), 32'd1);
        check("t37_dat_mis", seen_rdata,    32'd0);
        instr_req_i = 1'b0;
        cycle();
        check("t37_err_hi", 32'(seen_err), 32'd1);
        check("t37_dat_hi", seen_rdata,    32'd0);
        cycle();

        // Reset with two responses pending.
        rsp_stall_i  = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h4;
        cycle();
        cycle();
        instr_req_i = 1'b0;
        cycle();
        check("t38_pre_out", seen_out, 32'd2);
        rst_ni      = 1'b0;
        rsp_stall_i = 1'b0;
        exp_q.delete();
        cycle();
        check("t38_rst_out", seen_out,     32'd0);
        check("t38_rst_rv",  32'(seen_rv), 32'd0);
        rst_ni = 1'b1;
        cycle();
        check("t38_post_rv0", 32'(seen_rv), 32'd0);
        cycle();
        check("t38_post_rv1", 32'(seen_rv), 32'd0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h4;
        cycle();
        instr_req_i = 1'b0;
        cycle();
        check("t38_mem_kept", seen_rdata, 32'h0A);

        // Preload write racing a grant to the same word.
        load_we_i    = 1'b1;
        load_addr_i  = AW'(3);
        load_wdata_i = 32'h55;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'hC;
        cycle();
        load_we_i = 1'b0;
        cycle();
        check("t39_old", seen_rdata, 32'h44);
        instr_req_i = 1'b0;
        cycle();
        check("t39_new", seen_rdata, 32'h55);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            instr_req_i = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       instr_addr_i = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
                1:       instr_addr_i = 32'(4 * MEM_WORDS) + (32'($urandom_range(0, 3)) << 2);
                2:       instr_addr_i = $urandom;
                default: instr_addr_i = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            endcase
            gnt_stall_i  = ($urandom_range(0, 4) == 0);
            rsp_stall_i  = ($urandom_range(0, 3) == 0);
            load_we_i    = ($urandom_range(0, 5) == 0);
            load_addr_i  = AW'($urandom_range(0, MEM_WORDS - 1));
            load_wdata_i = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst_ni    = 1'b0;
                load_we_i = 1'b0;
                exp_q.delete();
                cycle();
                rst_ni = 1'b1;
            end
            cycle();
        end

        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();
        check("drain_out", 32'(outstanding_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
